bpu_ctrl: RTL and testbench

BPU_CTRL -- requirements
Module: bpu_ctrl

---
 rtl/bpu_ctrl.sv | 162 ++++++++++++++++
 tb/tb_bpu_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpu_ctrl.sv
// Branch prediction control: BTB lookup and 2-bit counter prediction at fetch,
// F->D->E prediction tracking, and mispredict detection / table update at execute.
module bpu_ctrl (
   input  logic        clk_i,
   input  logic        rst_ni,

   input  logic [31:0] pc_f_i,
   input  logic        stall_d_i,
   input  logic        flush_d_i,
   input  logic        stall_e_i,
   input  logic        flush_e_i,

   input  logic [31:0] btb_target_i,
   input  logic [19:0] btb_tag_i,
   input  logic        btb_valid_i,
   output logic [9:0]  btb_rd_addr_o,
   output logic        btb_wr_en_o,
   output logic        btb_wr_valid_o,
   output logic [9:0]  btb_wr_addr_o,
   output logic [19:0] btb_wr_tag_o,
   output logic [31:0] btb_wr_target_o,

   output logic        pred_taken_f_o,
   output logic [31:0] pc_next_f_o,

   input  logic        ex_is_branch_i,
   input  logic        ex_taken_i,
   input  logic [31:0] ex_target_i,
   output logic        mispredict_e_o,
   output logic [31:0] pc_redirect_e_o
);

   localparam int unsigned IDX_W     = 10;
   localparam int unsigned TAG_W     = 20;
   localparam int unsigned CNT_W     = 2;
   localparam int unsigned N_ENTRIES = 1024;
   localparam int unsigned PC_W      = 32;

   localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(3);
   localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(0);
   localparam logic [PC_W-1:0]  PC_INC  = PC_W'(4);

   typedef struct packed {
      logic            valid;
      logic [PC_W-1:0] pc;
      logic            pred_taken;
      logic [PC_W-1:0] pred_target;
   } stage_t;

   logic [CNT_W-1:0] cnt_q [N_ENTRIES];

   logic [IDX_W-1:0] idx_f;
   logic [TAG_W-1:0] tag_f;
   logic             hit_f;
   logic [CNT_W-1:0] cnt_f;
   logic [PC_W-1:0]  pc_seq_f;

   stage_t           d_in;
   stage_t           d_q;
   stage_t           e_q;

   logic [IDX_W-1:0] idx_e;
   logic [PC_W-1:0]  pc_seq_e;
   logic             br_taken_e;
   logic             dir_miss_e;
   logic             tgt_miss_e;
   logic             alias_e;
   logic             upd_en_e;
   logic             cnt_we_e;
   logic [CNT_W-1:0] cnt_e;
   logic [CNT_W-1:0] cnt_d_e;

   // Fetch-stage lookup: BTB hit qualified by the direction counter's MSB.
   assign idx_f          = pc_f_i[11:2];
   assign tag_f          = pc_f_i[31:12];
   assign btb_rd_addr_o  = idx_f;
   assign hit_f          = btb_valid_i && (btb_tag_i == tag_f);
   assign cnt_f          = cnt_q[idx_f];
   assign pc_seq_f       = pc_f_i + PC_INC;
   assign pred_taken_f_o = hit_f && cnt_f[CNT_W-1];
   assign pc_next_f_o    = pred_taken_f_o ? btb_target_i : pc_seq_f;

   always_comb begin
      d_in             = '0;
      d_in.valid       = 1'b1;
      d_in.pc          = pc_f_i;
      d_in.pred_taken  = pred_taken_f_o;
      d_in.pred_target = pc_next_f_o;
   end

   // F->D register; flush dominates stall and only kills valid/prediction.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         d_q <= '0;
      end else if (flush_d_i) begin
         d_q.valid      <= 1'b0;
         d_q.pred_taken <= 1'b0;
      end else if (!stall_d_i) begin
         d_q <= d_in;
      end
   end

   // D->E register, same flush/stall priority as F->D.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         e_q <= '0;
      end else if (flush_e_i) begin
         e_q.valid      <= 1'b0;
         e_q.pred_taken <= 1'b0;
      end else if (!stall_e_i) begin
         e_q <= d_q;
      end
   end

   // Execute-stage resolution against the prediction carried down the pipe.
   assign idx_e      = e_q.pc[11:2];
   assign pc_seq_e   = e_q.pc + PC_INC;
   assign br_taken_e = ex_is_branch_i && ex_taken_i;
   assign dir_miss_e = ex_is_branch_i && (ex_taken_i != e_q.pred_taken);
   assign tgt_miss_e = br_taken_e && (ex_target_i != e_q.pred_target);
   assign alias_e    = !ex_is_branch_i && e_q.pred_taken;

   assign mispredict_e_o  = e_q.valid && (dir_miss_e || tgt_miss_e || alias_e);
   assign pc_redirect_e_o = br_taken_e ? ex_target_i : pc_seq_e;

   assign upd_en_e = e_q.valid && !stall_e_i;
   assign cnt_we_e = upd_en_e && ex_is_branch_i;
   assign cnt_e    = cnt_q[idx_e];

   always_comb begin
      cnt_d_e = cnt_e;
      if (ex_taken_i) begin
         if (cnt_e != CNT_MAX) begin
            cnt_d_e = cnt_e + CNT_W'(1);
         end
      end else begin
         if (cnt_e != CNT_MIN) begin
            cnt_d_e = cnt_e - CNT_W'(1);
         end
      end
   end

   // Taken branches install/refresh the entry; aliased non-branches invalidate it.
   assign btb_wr_en_o     = upd_en_e && (br_taken_e || alias_e);
   assign btb_wr_valid_o  = br_taken_e;
   assign btb_wr_addr_o   = idx_e;
   assign btb_wr_tag_o    = e_q.pc[31:12];
   assign btb_wr_target_o = ex_target_i;

   // Counter table; fetch reads cnt_q directly so a same-cycle write is not bypassed.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < N_ENTRIES; i++) begin
            cnt_q[i] <= CNT_RST;
         end
      end else if (cnt_we_e) begin
         cnt_q[idx_e] <= cnt_d_e;
      end
   end

endmodule

// File: tb/tb_bpu_ctrl.sv
// Directed bench for bpu_ctrl: fetch prediction, execute resolution, counter
// saturation, aliasing, stall/flush handling and asynchronous reset.
module tb_bpu_ctrl;

   logic        clk_i;
   logic        rst_ni;
   logic [31:0] pc_f_i;
   logic        stall_d_i, flush_d_i, stall_e_i, flush_e_i;
   logic [31:0] btb_target_i;
   logic [19:0] btb_tag_i;
   logic        btb_valid_i;
   logic [9:0]  btb_rd_addr_o;
   logic        btb_wr_en_o, btb_wr_valid_o;
   logic [9:0]  btb_wr_addr_o;
   logic [19:0] btb_wr_tag_o;
   logic [31:0] btb_wr_target_o;
   logic        pred_taken_f_o;
   logic [31:0] pc_next_f_o;
   logic        ex_is_branch_i, ex_taken_i;
   logic [31:0] ex_target_i;
   logic        mispredict_e_o;
   logic [31:0] pc_redirect_e_o;

   int n_vec = 0;
   int n_err = 0;

   bpu_ctrl dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .pc_f_i          (pc_f_i),
      .stall_d_i       (stall_d_i),
      .flush_d_i       (flush_d_i),
      .stall_e_i       (stall_e_i),
      .flush_e_i       (flush_e_i),
      .btb_target_i    (btb_target_i),
      .btb_tag_i       (btb_tag_i),
      .btb_valid_i     (btb_valid_i),
      .btb_rd_addr_o   (btb_rd_addr_o),
      .btb_wr_en_o     (btb_wr_en_o),
      .btb_wr_valid_o  (btb_wr_valid_o),
      .btb_wr_addr_o   (btb_wr_addr_o),
      .btb_wr_tag_o    (btb_wr_tag_o),
      .btb_wr_target_o (btb_wr_target_o),
      .pred_taken_f_o  (pred_taken_f_o),
      .pc_next_f_o     (pc_next_f_o),
      .ex_is_branch_i  (ex_is_branch_i),
      .ex_taken_i      (ex_taken_i),
      .ex_target_i     (ex_target_i),
      .mispredict_e_o  (mispredict_e_o),
      .pc_redirect_e_o (pc_redirect_e_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Apply fetch-side and execute-side inputs, then settle to mid-cycle.
   task automatic drive(input logic [31:0] pc, input logic bv, input logic [19:0] tag,
                        input logic [31:0] tgt, input logic br, input logic tk,
                        input logic [31:0] xt);
      pc_f_i = pc; btb_valid_i = bv; btb_tag_i = tag; btb_target_i = tgt;
      ex_is_branch_i = br; ex_taken_i = tk; ex_target_i = xt;
      #4;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic quiet(input int n);
      for (int i = 0; i < n; i++) begin
         drive(32'hF00, 1'b0, 20'h0, 32'h0, 1'b0, 1'b0, 32'h0);
         tick();
      end
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      stall_d_i = 1'b0; flush_d_i = 1'b0; stall_e_i = 1'b0; flush_e_i = 1'b0;
      #1;
      drive(32'h100, 1'b0, 20'h0, 32'h0, 1'b1, 1'b1, 32'h200);
      n_vec++; if (pred_taken_f_o !== 1'b0) begin n_err++; $display("FAIL reset_pred: got %0h want 0", pred_taken_f_o); end
      n_vec++; if (pc_next_f_o !== 32'h104) begin n_err++; $display("FAIL reset_next: got %0h want 104", pc_next_f_o); end
      n_vec++; if (btb_rd_addr_o !== 10'h040) begin n_err++; $display("FAIL reset_rdaddr: got %0h want 040", btb_rd_addr_o); end
      n_vec++; if (mispredict_e_o !== 1'b0) begin n_err++; $display("FAIL reset_mispredict: got %0h want 0", mispredict_e_o); end
      n_vec++; if (btb_wr_en_o !== 1'b0) begin n_err++; $display("FAIL reset_wren: got %0h want 0", btb_wr_en_o); end
      tick();
      tick();
      rst_ni = 1'b1;
   endtask

   task automatic test_taken_branch();
      drive(32'h100, 1'b0, 20'h0, 32'h0, 1'b1, 1'b1, 32'h200);
      n_vec++; if (mispredict_e_o !== 1'b0) begin n_err++; $display("FAIL e_invalid_mispredict: got %0h want 0", mispredict_e_o); end
      n_vec++; if (btb_wr_en_o !== 1'b0) begin n_err++; $display("FAIL e_invalid_wren: got %0h want 0", btb_wr_en_o); end
      tick();
      drive(32'h104, 1'b0, 20'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
      drive(32'h108, 1'b0, 20'h0, 32'h0, 1'b1, 1'b1, 32'h200);
      n_vec++; if (mispredict_e_o !== 1'b1) begin n_err++; $display("FAIL taken_mispredict: got %0h want 1", mispredict_e_o); end
      n_vec++; if (pc_redirect_e_o !== 32'h200) begin n_err++; $display("FAIL taken_redirect: got %0h want 200", pc_redirect_e_o); end
      n_vec++; if (btb_wr_en_o !== 1'b1) begin n_err++; $display("FAIL taken_wren: got %0h want 1", btb_wr_en_o); end
      n_vec++; if (btb_wr_valid_o !== 1'b1) begin n_err++; $display("FAIL taken_wrvalid: got %0h want 1", btb_wr_valid_o); end
      n_vec++; if (btb_wr_addr_o !== 10'h040) begin n_err++; $display("FAIL taken_wraddr: got %0h want 040", btb_wr_addr_o); end
      n_vec++; if (btb_wr_tag_o !== 20'h00000) begin n_err++; $display("FAIL taken_wrtag: got %0h want 0", btb_wr_tag_o); end
      n_vec++; if (btb_wr_target_o !== 32'h200) begin n_err++; $display("FAIL taken_wrtarget: got %0h want 200", btb_wr_target_o); end
      tick();
      drive(32'h10C, 1'b0, 20'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      n_vec++; if (mispredict_e_o !== 1'b0) begin n_err++; $display("FAIL seq_mispredict: got %0h want 0", mispredict_e_o); end
      n_vec++; if (btb_wr_en_o !== 1'b0) begin n_err++; $display("FAIL seq_wren: got %0h want 0", btb_wr_en_o); end
      n_vec++; if (pc_redirect_e_o !== 32'h108) begin n_err++; $display("FAIL seq_redirect: got %0h want 108", pc_redirect_e_o); end
      tick();
      quiet(2);
   endtask

   task automatic test_predicted_taken();
      drive(32'h100, 1'b1, 20'h0, 32'h200, 1'b0, 1'b0, 32'h0);
      n_vec++; if (pred_taken_f_o !== 1'b1) begin n_err++; $display("FAIL hit_pred: got %0h want 1", pred_taken_f_o); end
      n_vec++; if (pc_next_f_o !== 32'h200) begin n_err++; $display("FAIL hit_next: got %0h want 200", pc_next_f_o); end
      tick();
      drive(32'h1100, 1'b1, 20'h0, 32'h200, 1'b0, 1'b0, 32'h0);
      n_vec++; if (pred_taken_f_o !== 1'b0) begin n_err++; $display("FAIL tagmiss_pred: got %0h want 0", pred_taken_f_o); end
      n_vec++; if (pc_next_f_o !== 32'h1104) begin n_err++; $display("FAIL tagmiss_next: got %0h want 1104", pc_next_f_o); end
      tick();
      drive(32'h204, 1'b0, 20'h0, 32'h0, 1'b1, 1'b1, 32'h200);
      n_vec++; if (mispredict_e_o !== 1'b0) begin n_err++; $display("FAIL correct_mispredict: got %0h want 0", mispredict_e_o); end
      n_vec++; if (pc_redirect_e_o !== 32'h200) begin n_err++; $display("FAIL correct_redirect: got %0h want 200", pc_redirect_e_o); end
      n_vec++; if (btb_wr_en_o !== 1'b1) begin n_err++; $display("FAIL correct_wren: got %0h want 1", btb_wr_en_o); end
      tick();
      quiet(2);
   endtask

   task automatic test_target_mismatch();
      drive(32'h100, 1'b1, 20'h0, 32'h200, 1'b0, 1'b0, 32'h0);
      n_vec++; if (pred_taken_f_o !== 1'b1) begin n_err++; $display("FAIL cnt3_pred: got %0h want 1", pred_taken_f_o); end
      tick();
      drive(32'h200, 1'b0, 20'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
      drive(32'h204, 1'b0, 20'h0, 32'h0, 1'b1, 1'b1, 32'h300);
      n_vec++; if (mispredict_e_o !== 1'b1) begin n_err++; $display("FAIL tgt_mispredict: got %0h want 1", mispredict_e_o); end
      n_vec++; if (pc_redirect_e_o !== 32'h300) begin n_err++; $display("FAIL tgt_redirect: got %0h want 300", pc_redirect_e_o); end
      n_vec++; if (btb_wr_target_o !== 32'h300) begin n_err++; $display("FAIL tgt_wrtarget: got %0h want 300", btb_wr_target_o); end
      tick();
      quiet(2);
   endtask

   task automatic test_alias();
      drive(32'h1100, 1'b1, 20'h00001, 32'h200, 1'b0, 1'b0, 32'h0);
      n_vec++; if (pred_taken_f_o !== 1'b1) begin n_err++; $display("FAIL alias_pred: got %0h want 1", pred_taken_f_o); end
      tick();
      drive(32'h200, 1'b0, 20'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
      drive(32'h204, 1'b0, 20'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      n_vec++; if (mispredict_e_o !== 1'b1) begin n_err++; $display("FAIL alias_mispredict: got %0h want 1", mispredict_e_o); end
      n_vec++; if (pc_redirect_e_o !== 32'h1104) begin n_err++; $display("FAIL alias_redirect: got %0h want 1104", pc_redirect_e_o); end
      n_vec++; if (btb_wr_en_o !== 1'b1) begin n_err++; $display("FAIL alias_wren: got %0h want 1", btb_wr_en_o); end
      n_vec++; if (btb_wr_valid_o !== 1'b0) begin n_err++; $display("FAIL alias_wrvalid: got %0h want 0", btb_wr_valid_o); end
      n_vec++; if (btb_wr_addr_o !== 10'h040) begin n_err++; $display("FAIL alias_wraddr: got %0h want 040", btb_wr_addr_o); end
      tick();
      quiet(2);
   endtask

   // Counter starts at 3; four back-to-back fetches all read a taken prediction.
   task automatic test_not_taken_saturate();
      drive(32'h100, 1'b1, 20'h0, 32'h200, 1'b0, 1'b0, 32'h0);
      n_vec++; if (pred_taken_f_o !== 1'b1) begin n_err++; $display("FAIL nt_f0_pred: got %0h want 1", pred_taken_f_o); end
      tick();
      drive(32'h100, 1'b1, 20'h0, 32'h200, 1'b0, 1'b0, 32'h0);
      tick();
      drive(32'h100, 1'b1, 20'h0, 32'h200, 1'b1, 1'b0, 32'h0);
      n_vec++; if (pred_taken_f_o !== 1'b1) begin n_err++; $display("FAIL nt_nobypass_pred: got %0h want 1", pred_taken_f_o); end
      n_vec++; if (mispredict_e_o !== 1'b1) begin n_err++; $display("FAIL nt_r0_mispredict: got %0h want 1", mispredict_e_o); end
      n_vec++; if (pc_redirect_e_o !== 32'h104) begin n_err++; $display("FAIL nt_r0_redirect: got %0h want 104", pc_redirect_e_o); end
      n_vec++; if (btb_wr_en_o !== 1'b0) begin n_err++; $display("FAIL nt_r0_wren: got %0h want 0", btb_wr_en_o); end
      tick();
      drive(32'h100, 1'b1, 20'h0, 32'h200, 1'b1, 1'b0, 32'h0);
      n_vec++; if (pred_taken_f_o !== 1'b1) begin n_err++; $display("FAIL nt_cnt2_pred: got %0h want 1", pred_taken_f_o); end
      n_vec++; if (mispredict_e_o !== 1'b1) begin n_err++; $display("FAIL nt_r1_mispredict: got %0h want 1", mispredict_e_o); end
      tick();
      drive(32'h300, 1'b0, 20'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      n_vec++; if (mispredict_e_o !== 1'b1) begin n_err++; $display("FAIL nt_r2_mispredict: got %0h want 1", mispredict_e_o); end
      n_vec++; if (pc_redirect_e_o !== 32'h104) begin n_err++; $display("FAIL nt_r2_redirect: got %0h want 104", pc_redirect_e_o); end
      tick();
      drive(32'h304, 1'b0, 20'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      n_vec++; if (mispredict_e_o !== 1'b1) begin n_err++; $display("FAIL nt_r3_mispredict: got %0h want 1", mispredict_e_o); end
      tick();
      drive(32'h100, 1'b1, 20'h0, 32'h200, 1'b0, 1'b0, 32'h0);
      n_vec++; if (pred_taken_f_o !== 1'b0) begin n_err++; $display("FAIL nt_cnt0_pred: got %0h want 0", pred_taken_f_o); end
      n_vec++; if (pc_next_f_o !== 32'h104) begin n_err++; $display("FAIL nt_cnt0_next: got %0h want 104", pc_next_f_o); end
      tick();
      drive(32'h104, 1'b0, 20'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
      drive(32'h108, 1'b0, 20'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      n_vec++; if (mispredict_e_o !== 1'b0) begin n_err++; $display("FAIL nt_correct_mispredict: got %0h want 0", mispredict_e_o); end
      tick();
      drive(32'h100, 1'b1, 20'h0, 32'h200, 1'b0, 1'b0, 32'h0);
      n_vec++; if (pred_taken_f_o !== 1'b0) begin n_err++; $display("FAIL nt_floor_pred: got %0h want 0", pred_taken_f_o); end
      tick();
      quiet(2);
   endtask

   task automatic test_stall_d();
      drive(32'h700, 1'b0, 20'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
      stall_d_i = 1'b1; stall_e_i = 1'b1;
      drive(32'h704, 1'b0, 20'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
      stall_d_i = 1'b0; stall_e_i = 1'b0;
      drive(32'h708, 1'b0, 20'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
      drive(32'h70C, 1'b0, 20'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      n_vec++; if (pc_redirect_e_o !== 32'h704) begin n_err++; $display("FAIL stall_held_redirect: got %0h want 704", pc_redirect_e_o); end
      n_vec++; if (btb_wr_addr_o !== 10'h1C0) begin n_err++; $display("FAIL stall_held_wraddr: got %0h want 1c0", btb_wr_addr_o); end
      tick();
      drive(32'h710, 1'b0, 20'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      n_vec++; if (pc_redirect_e_o !== 32'h70C) begin n_err++; $display("FAIL stall_next_redirect: got %0h want 70c", pc_redirect_e_o); end
      tick();
      quiet(2);
   endtask

   task automatic test_flush_d();
      drive(32'h900, 1'b0, 20'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
      flush_d_i = 1'b1;
      drive(32'h904, 1'b0, 20'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
      flush_d_i = 1'b0;
      drive(32'h908, 1'b0, 20'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      n_vec++; if (pc_redirect_e_o !== 32'h904) begin n_err++; $display("FAIL flushd_prev_redirect: got %0h want 904", pc_redirect_e_o); end
      tick();
      drive(32'h90C, 1'b0, 20'h0, 32'h0, 1'b1, 1'b1, 32'hA00);
      n_vec++; if (mispredict_e_o !== 1'b0) begin n_err++; $display("FAIL flushd_mispredict: got %0h want 0", mispredict_e_o); end
      n_vec++; if (btb_wr_en_o !== 1'b0) begin n_err++; $display("FAIL flushd_wren: got %0h want 0", btb_wr_en_o); end
      tick();
      quiet(2);
   endtask

   task automatic test_stall_flush_e();
      drive(32'h500, 1'b0, 20'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
      stall_e_i = 1'b1; flush_e_i = 1'b1;
      drive(32'h504, 1'b0, 20'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
      stall_e_i = 1'b0; flush_e_i = 1'b0;
      drive(32'h508, 1'b0, 20'h0, 32'h0, 1'b1, 1'b1, 32'h600);
      n_vec++; if (mispredict_e_o !== 1'b0) begin n_err++; $display("FAIL flushe_mispredict: got %0h want 0", mispredict_e_o); end
      n_vec++; if (btb_wr_en_o !== 1'b0) begin n_err++; $display("FAIL flushe_wren: got %0h want 0", btb_wr_en_o); end
      tick();
      drive(32'h50C, 1'b0, 20'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
      drive(32'h500, 1'b1, 20'h0, 32'h600, 1'b0, 1'b0, 32'h0);
      n_vec++; if (pred_taken_f_o !== 1'b0) begin n_err++; $display("FAIL flushe_no_cnt_write: got %0h want 0", pred_taken_f_o); end
      tick();
      quiet(2);
   endtask

   task automatic test_async_reset();
      drive(32'hA00, 1'b0, 20'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
      drive(32'hA04, 1'b0, 20'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
      drive(32'hA08, 1'b0, 20'h0, 32'h0, 1'b1, 1'b1, 32'hB00);
      n_vec++; if (mispredict_e_o !== 1'b1) begin n_err++; $display("FAIL pre_rst_mispredict: got %0h want 1", mispredict_e_o); end
      rst_ni = 1'b0;
      #1;
      n_vec++; if (mispredict_e_o !== 1'b0) begin n_err++; $display("FAIL async_rst_mispredict: got %0h want 0", mispredict_e_o); end
      n_vec++; if (btb_wr_en_o !== 1'b0) begin n_err++; $display("FAIL async_rst_wren: got %0h want 0", btb_wr_en_o); end
      tick();
      rst_ni = 1'b1;
      drive(32'hA10, 1'b0, 20'h0, 32'h0, 1'b1, 1'b1, 32'hB00);
      n_vec++; if (mispredict_e_o !== 1'b0) begin n_err++; $display("FAIL post_rst0_mispredict: got %0h want 0", mispredict_e_o); end
      tick();
      drive(32'hA14, 1'b0, 20'h0, 32'h0, 1'b1, 1'b1, 32'hB00);
      n_vec++; if (mispredict_e_o !== 1'b0) begin n_err++; $display("FAIL post_rst1_mispredict: got %0h want 0", mispredict_e_o); end
      tick();
      drive(32'hA18, 1'b0, 20'h0, 32'h0, 1'b1, 1'b1, 32'hB00);
      n_vec++; if (mispredict_e_o !== 1'b1) begin n_err++; $display("FAIL post_rst2_mispredict: got %0h want 1", mispredict_e_o); end
      n_vec++; if (pc_redirect_e_o !== 32'hB00) begin n_err++; $display("FAIL post_rst2_redirect: got %0h want b00", pc_redirect_e_o); end
      tick();
   endtask

   initial begin
      test_reset();
      test_taken_branch();
      test_predicted_taken();
      test_target_mismatch();
      test_alias();
      test_not_taken_saturate();
      test_stall_d();
      test_flush_d();
      test_stall_flush_e();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
